// File: rtl/npc_pc_gen_pkg.sv
// npc_pc_gen_pkg: shared definitions for the next-PC generator.
//   - br_op_e    : branch-type encodings on the br_op bus
//   - NPC_*      : default reset/handler vectors and legal fetch window
//   - sat_inc    : saturating 32-bit increment used by the optional counters
//                  (NPC_PERF_CNT_EN)
package npc_pc_gen_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } br_op_e;

  localparam logic [31:0] NPC_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] NPC_HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] NPC_IMEM_LO    = 32'h0000_3000;
  localparam logic [31:0] NPC_IMEM_HI    = 32'h0000_6FFC;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/npc_pc_gen_if.sv
// npc_pc_gen_if: D-stage redirect inputs and F-stage PC outputs of npc_pc_gen.
//   master : decode/CP0 side (drives stall, branch/jump/exception controls,
//            reads f_pc, f_pc4, f_adel, redirect)
//   slave  : the PC generator
// With NPC_PERF_CNT_EN defined, perf_redirects/perf_stalls are added.
interface npc_pc_gen_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic [ADDR_W-1:0] d_pc;
  logic [2:0]        br_op;
  logic [31:0]       rs_val;
  logic [31:0]       rt_val;
  logic [15:0]       br_imm16;
  logic              j_en;
  logic [25:0]       j_imm26;
  logic              jr_en;
  logic [ADDR_W-1:0] jr_target;
  logic              exc_req;
  logic              eret;
  logic [ADDR_W-1:0] epc;
  logic [ADDR_W-1:0] f_pc;
  logic [ADDR_W-1:0] f_pc4;
  logic              f_adel;
  logic              redirect;
`ifdef NPC_PERF_CNT_EN
  logic [31:0]       perf_redirects;
  logic [31:0]       perf_stalls;
`endif

  modport master (
    output stall, d_pc, br_op, rs_val, rt_val, br_imm16, j_en, j_imm26,
           jr_en, jr_target, exc_req, eret, epc,
`ifdef NPC_PERF_CNT_EN
    input  perf_redirects, perf_stalls,
`endif
    input  f_pc, f_pc4, f_adel, redirect
  );

  modport slave (
    input  stall, d_pc, br_op, rs_val, rt_val, br_imm16, j_en, j_imm26,
           jr_en, jr_target, exc_req, eret, epc,
`ifdef NPC_PERF_CNT_EN
    output perf_redirects, perf_stalls,
`endif
    output f_pc, f_pc4, f_adel, redirect
  );

endinterface

// File: rtl/npc_br_cmp.sv
// npc_br_cmp: combinational branch-condition evaluator.
//   br_op  : branch type (br_op_e encoding, reserved treated as none)
//   rs_val : forwarded rs operand (compared as signed 32-bit)
//   rt_val : forwarded rt operand
//   taken  : branch condition holds
module npc_br_cmp
  import npc_pc_gen_pkg::*;
(
  input  logic [2:0]  br_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        taken
);

  logic signed [31:0] rs_s;
  logic signed [31:0] rt_s;

  assign rs_s = $signed(rs_val);
  assign rt_s = $signed(rt_val);

  always_comb begin
    taken = 1'b0;
    case (br_op_e'(br_op))
      BR_BEQ:  taken = (rs_s == rt_s);
      BR_BNE:  taken = (rs_s != rt_s);
      BR_BLEZ: taken = (rs_s <= 32'sd0);
      BR_BGTZ: taken = (rs_s >  32'sd0);
      BR_BLTZ: taken = (rs_s <  32'sd0);
      BR_BGEZ: taken = (rs_s >= 32'sd0);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/npc_pc_gen.sv
// npc_pc_gen: F-stage PC register and next-PC select.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : npc_pc_gen_if.slave (D-stage redirects, exception/eret,
//                stall in; f_pc, f_pc4, f_adel, redirect out)
// Next-PC priority: exception > eret > taken branch > j > jr > pc+4.
// Optional macro NPC_PERF_CNT_EN adds saturating redirect/stall counters.
module npc_pc_gen
  import npc_pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(NPC_RESET_PC),
  parameter logic [ADDR_W-1:0] HANDLER_PC = ADDR_W'(NPC_HANDLER_PC),
  parameter logic [ADDR_W-1:0] IMEM_LO    = ADDR_W'(NPC_IMEM_LO),
  parameter logic [ADDR_W-1:0] IMEM_HI    = ADDR_W'(NPC_IMEM_HI)
) (
  input logic         clk,
  input logic         rst_n,
  npc_pc_gen_if.slave bus
);

  function automatic logic [ADDR_W-1:0] br_offset(input logic [15:0] imm);
    return {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
  endfunction

  logic [ADDR_W-1:0] f_pc_q;
  logic [ADDR_W-1:0] f_pc_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] next_pc;
  logic              br_taken;
  logic              non_seq;
  logic              hold;

  npc_br_cmp u_br_cmp (
    .br_op  (bus.br_op),
    .rs_val (bus.rs_val),
    .rt_val (bus.rt_val),
    .taken  (br_taken)
  );

  assign pc_plus4  = f_pc_q + ADDR_W'(4);
  assign br_target = bus.d_pc + ADDR_W'(4) + br_offset(bus.br_imm16);
  assign j_target  = {bus.d_pc[ADDR_W-1:28], bus.j_imm26, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (bus.exc_req)   next_pc = HANDLER_PC;
    else if (bus.eret) next_pc = bus.epc;
    else if (br_taken) next_pc = br_target;
    else if (bus.j_en) next_pc = j_target;
    else if (bus.jr_en) next_pc = bus.jr_target;
  end

  // Exceptions and eret override a hazard stall; everything else waits.
  assign hold    = bus.stall && !bus.exc_req && !bus.eret;
  assign non_seq = bus.exc_req || bus.eret || br_taken || bus.j_en || bus.jr_en;

  always_comb begin
    f_pc_d = hold ? f_pc_q : next_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) f_pc_q <= RESET_PC;
    else        f_pc_q <= f_pc_d;
  end

  assign bus.f_pc     = f_pc_q;
  assign bus.f_pc4    = pc_plus4;
  assign bus.redirect = non_seq && !hold;
  // A wrapped or jr-supplied address lands here; CP0 decides what to do.
  assign bus.f_adel   = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IMEM_LO) ||
                        (f_pc_q > IMEM_HI);

`ifdef NPC_PERF_CNT_EN
  logic [31:0] perf_redirects_q;
  logic [31:0] perf_redirects_d;
  logic [31:0] perf_stalls_q;
  logic [31:0] perf_stalls_d;

  always_comb begin
    perf_redirects_d = bus.redirect ? sat_inc(perf_redirects_q) : perf_redirects_q;
    perf_stalls_d    = hold ? sat_inc(perf_stalls_q) : perf_stalls_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_redirects_q <= 32'd0;
      perf_stalls_q    <= 32'd0;
    end else begin
      perf_redirects_q <= perf_redirects_d;
      perf_stalls_q    <= perf_stalls_d;
    end
  end

  assign bus.perf_redirects = perf_redirects_q;
  assign bus.perf_stalls    = perf_stalls_q;
`endif

endmodule

// File: tb/tb_npc_pc_gen.sv
module tb_npc_pc_gen;

  localparam logic [31:0] RST_PC  = 32'h0000_3000;
  localparam logic [31:0] HND_PC  = 32'h0000_4180;
  localparam logic [31:0] LO      = 32'h0000_3000;
  localparam logic [31:0] HI      = 32'h0000_6FFC;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  npc_pc_gen_if #(.ADDR_W(32)) bus ();

  npc_pc_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
`ifdef NPC_PERF_CNT_EN
  logic [31:0] m_redir;
  logic [31:0] m_stalls;
`endif

  function automatic bit m_taken();
    int rs, rt;
    rs = int'(bus.rs_val);
    rt = int'(bus.rt_val);
    case (int'(bus.br_op))
      1: return rs == rt;
      2: return rs != rt;
      3: return rs <= 0;
      4: return rs > 0;
      5: return rs < 0;
      6: return rs >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_next();
    logic [31:0] off;
    off = 32'($signed(bus.br_imm16)) * 32'd4;
    if (bus.exc_req) return HND_PC;
    if (bus.eret)    return bus.epc;
    if (m_taken())   return bus.d_pc + 32'd4 + off;
    if (bus.j_en)    return (bus.d_pc & 32'hF000_0000) | (32'(bus.j_imm26) * 32'd4);
    if (bus.jr_en)   return bus.jr_target;
    return m_pc + 32'd4;
  endfunction

  function automatic bit m_hold();
    return bus.stall && !bus.exc_req && !bus.eret;
  endfunction

  function automatic bit m_redirect();
    if (m_hold()) return 1'b0;
    return bus.exc_req || bus.eret || m_taken() || bus.j_en || bus.jr_en;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = RST_PC;
`ifdef NPC_PERF_CNT_EN
      m_redir  = 0;
      m_stalls = 0;
`endif
    end else begin
`ifdef NPC_PERF_CNT_EN
      if (m_redirect() && m_redir != 32'hFFFF_FFFF) m_redir++;
      if (m_hold() && m_stalls != 32'hFFFF_FFFF) m_stalls++;
`endif
      if (!m_hold()) m_pc = m_next();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("f_pc", bus.f_pc, m_pc);
      chk("f_pc4", bus.f_pc4, m_pc + 32'd4);
      chk("f_adel", 32'(bus.f_adel),
          32'((m_pc % 4 != 0) || (m_pc < LO) || (m_pc > HI)));
      chk("redirect", 32'(bus.redirect), 32'(m_redirect()));
`ifdef NPC_PERF_CNT_EN
      chk("perf_redirects", bus.perf_redirects, m_redir);
      chk("perf_stalls", bus.perf_stalls, m_stalls);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clr();
    bus.stall = 0; bus.d_pc = 0; bus.br_op = 0; bus.rs_val = 0; bus.rt_val = 0;
    bus.br_imm16 = 0; bus.j_en = 0; bus.j_imm26 = 0; bus.jr_en = 0;
    bus.jr_target = 0; bus.exc_req = 0; bus.eret = 0; bus.epc = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst f_pc", bus.f_pc, 32'h3000);
    chk("rst f_pc4", bus.f_pc4, 32'h3004);
    chk("rst f_adel", 32'(bus.f_adel), 32'd0);
    step(); chk("seq1", bus.f_pc, 32'h3004);
    step(); chk("seq2", bus.f_pc, 32'h3008);

    // Branch table
    bus.d_pc = 32'h3010; bus.br_imm16 = 16'hFFFE;
    bus.br_op = 3'd4; bus.rs_val = 32'd1;
    #1 chk("bgtz redirect", 32'(bus.redirect), 32'd1);
    step(); chk("bgtz taken", bus.f_pc, 32'h300C);
    bus.rs_val = 32'd0;
    #1 chk("bgtz nt redirect", 32'(bus.redirect), 32'd0);
    step(); chk("bgtz not taken", bus.f_pc, 32'h3010);
    bus.br_op = 3'd3; bus.rs_val = 32'h8000_0000;
    step(); chk("blez signed", bus.f_pc, 32'h300C);

    // Stall vs redirect
    bus.stall = 1; bus.br_op = 3'd1; bus.rs_val = 32'd5; bus.rt_val = 32'd5;
    #1 chk("stall redirect", 32'(bus.redirect), 32'd0);
    step(); chk("stall hold", bus.f_pc, 32'h300C);
    bus.exc_req = 1;
    step(); chk("stall exc", bus.f_pc, 32'h4180);
    clr();

    // Priority
    bus.exc_req = 1; bus.eret = 1; bus.j_en = 1; bus.epc = 32'h3100;
    step(); chk("exc over eret", bus.f_pc, 32'h4180);
    bus.exc_req = 0; bus.j_en = 0;
    step(); chk("eret", bus.f_pc, 32'h3100);
    clr();

    // Fault flag
    bus.jr_en = 1; bus.jr_target = 32'h3002;
    step(); chk("adel misalign", 32'(bus.f_adel), 32'd1);
    bus.jr_target = 32'h7000;
    step(); chk("adel high", 32'(bus.f_adel), 32'd1);
    bus.jr_target = 32'h6FFC;
    step(); chk("adel edge", 32'(bus.f_adel), 32'd0);
    bus.jr_target = 32'hFFFF_FFFC;
    step(); chk("wrap pc4", bus.f_pc4, 32'h0);
    chk("wrap adel", 32'(bus.f_adel), 32'd1);
    clr();

    // Decoder error: branch beats j and jr
    bus.d_pc = 32'h3010; bus.br_imm16 = 16'hFFFE; bus.br_op = 3'd4; bus.rs_val = 32'd1;
    bus.j_en = 1; bus.j_imm26 = 26'h123; bus.jr_en = 1; bus.jr_target = 32'h5000;
    step(); chk("branch wins", bus.f_pc, 32'h300C);
    clr();

    // Jump to 0x3040 then async reset between edges
    bus.d_pc = 32'h3010; bus.j_en = 1; bus.j_imm26 = 26'h0000C10;
    step(); chk("jump", bus.f_pc, 32'h3040);
    clr();
    #1 rst_n = 1'b0;
    #1 chk("async reset", bus.f_pc, 32'h3000);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(); chk("post reset seq", bus.f_pc, 32'h3004);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/npc_pc_gen.md
Name: npc_pc_gen

Overview:
- Next-generation fetch-address generator: owns the F-stage PC register and selects the next PC every cycle.
- Sources, in priority order: exception entry, eret, D-stage branch/jump redirect, sequential fetch.
- Generalised over the previous next-PC logic:
  - parametrised address width and vectors;
  - six-way branch compare;
  - stall handling;
  - fetch-address fault flag.
- Sits between the D-stage decoder/forwarding mux and the instruction memory / F-D pipeline register.

Parameters:
- ADDR_W, 32, PC width; all address arithmetic is modulo 2^ADDR_W.
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- HANDLER_PC, 32'h0000_4180, exception entry vector.
- IMEM_LO, 32'h0000_3000, lowest legal fetch address (inclusive).
- IMEM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hazard stall; holds PC unless an exception or eret is present
- d_pc  in  ADDR_W  PC of the instruction in D
- br_op  in  3  branch type: 0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved (treated as none)
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- br_imm16  in  16  branch offset
- j_en  in  1  j/jal in D
- j_imm26  in  26  jump index
- jr_en  in  1  jr/jalr in D
- jr_target  in  ADDR_W  forwarded register target
- exc_req  in  1  exception/interrupt accepted this cycle
- eret  in  1  eret accepted this cycle
- epc  in  ADDR_W  CP0 EPC
- f_pc  out  ADDR_W  current fetch PC (registered)
- f_pc4  out  ADDR_W  f_pc + 4
- f_adel  out  1  fetch address error: f_pc[1:0] != 0, or f_pc < IMEM_LO, or f_pc > IMEM_HI
- redirect  out  1  combinational; next PC is non-sequential (a taken branch, a jump, exc_req or eret)

Behaviour:
- Reset: async on rst_n low.
  - f_pc = RESET_PC; f_pc4 = RESET_PC + 4; f_adel = 0 for the default vectors.
  - Optional counters clear to 0.
  - Release takes effect at the first rising edge with rst_n high.
- next_pc priority:
  1. exc_req → HANDLER_PC
  2. eret → epc (no +4; the handler adjusts EPC)
  3. taken branch → d_pc + 4 + sext(br_imm16) << 2
  4. j_en → {d_pc[31:28], j_imm26, 2'b00}
  5. jr_en → jr_target (no alignment correction; a misaligned target raises f_adel next cycle)
  6. otherwise → f_pc + 4
- Branch conditions, signed 32-bit:
  - beq: rs == rt; bne: rs != rt
  - blez: rs <= 0; bgtz: rs > 0
  - bltz: rs < 0; bgez: rs >= 0
- Update rule:
  - f_pc <= next_pc on every rising edge when !stall || exc_req || eret.
  - When stall && !exc_req && !eret, f_pc holds and redirect is forced to 0. The D instruction is re-evaluated once the stall drops.
- Latency: one cycle. A redirect seen in cycle N appears on f_pc in cycle N+1; there is no delay-slot handling inside this block.
- Simultaneous events: exc_req together with eret → HANDLER_PC. Branch, j and jr asserted together (decoder error) → branch wins.
- Wrap-around: f_pc4 and the branch target wrap modulo 2^ADDR_W with no flag raised. A wrapped address is then caught by the f_adel range check.
- f_adel is combinational from f_pc. The block takes no action on it; CP0 consumes it.

Optional Feature:
- Macro: NPC_PERF_CNT_EN.
- Defined: adds outputs perf_redirects[31:0] and perf_stalls[31:0].
  - perf_redirects increments on each clock edge where the PC was updated with redirect = 1.
  - perf_stalls increments on each cycle with the hold condition true.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - br_op encodings (BR_NONE..BR_BGEZ);
  - default RESET_PC and HANDLER_PC constants;
  - IMEM bounds.
- One natural sub-module: npc_br_cmp, the combinational br_op/rs/rt → taken evaluator, reused by the verifier's reference model.

Test Plan:
- Reset and sequential fetch: rst_n low then high → f_pc = 0x3000 at release; f_pc = 0x3004 after the first edge; 0x3008 after the second.
- Branch table: d_pc = 0x3010, br_imm16 = 0xFFFE.
  - bgtz with rs = 1 → next f_pc = 0x300C.
  - bgtz with rs = 0 → f_pc + 4.
  - blez with rs = 0x8000_0000 → 0x300C (signed compare).
- Stall vs. redirect:
  - stall = 1 with beq taken → f_pc unchanged and redirect = 0.
  - Same stall with exc_req = 1 → f_pc = 0x4180 next cycle.
- Priority: exc_req = eret = j_en = 1, epc = 0x3100 → f_pc = 0x4180. Then eret alone → f_pc = 0x3100.
- Fault flag:
  - jr_target = 0x3002 → next cycle f_adel = 1.
  - jr_target = 0x7000 → f_adel = 1.
  - jr_target = 0x6FFC → f_adel = 0.
- Async reset mid-operation: assert rst_n low between edges while f_pc = 0x3040 → f_pc = 0x3000 immediately, without waiting for a clock edge.
